// File: rtl/apb_slave_mem.sv
// APB completer with a byte-wide register memory, programmable wait states
// and an error response for addresses outside the mapped window.
module apb_slave_mem #(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned AW1   = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   write_q, write_d;
    logic                   err_q, err_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
    logic                   mem_we;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]  offset_c;
    logic [IDX_W-1:0]       idx_c;
    logic                   err_c;

    // Address decode of the live bus address, used only at a setup latch
    always_comb begin
        offset_c = PADDR - BASE_ADDR;
        idx_c    = offset_c[IDX_W-1:0];
        err_c    = (PADDR < BASE_ADDR) ||
                   ({1'b0, offset_c} >= AW1'(MEM_DEPTH));
    end

    // State and transfer-context registers
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
        end
    end

    // Next-state logic; a setup in either state re-latches the transfer context
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        prdata_d = prdata_q;
        mem_we   = 1'b0;

        if (PSEL && !PENABLE) begin
            state_d  = ACCESS;
            cnt_d    = CNT_W'(WAIT_CYCLES);
            idx_d    = idx_c;
            write_d  = PWRITE;
            err_d    = err_c;
            wdata_d  = PWDATA;
            prdata_d = err_c ? '0 : mem[idx_c];
        end else if (state_q == ACCESS) begin
            if (!PSEL) begin
                state_d = IDLE;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                mem_we  = write_q && !err_q;
                state_d = IDLE;
            end
        end
    end

    // Memory array, cleared on reset and written at the completion edge
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Response outputs decoded from registered state only
    assign PREADY  = (state_q == ACCESS) && (cnt_q == '0);
    assign PSLVERR = PREADY && err_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: the driver queues the expected response
// of each transfer, and a negedge monitor checks every completion against it.
module tb_apb_slave_mem;

    localparam int unsigned EXP_WAITS = 2;

    logic        PCLK;
    logic        PRESET;
    logic [15:0] PADDR;
    logic [7:0]  PWDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    typedef struct packed {
        logic       is_read;
        logic [7:0] rdata;
        logic       err;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  waits = 0;

    apb_slave_mem dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every completed transfer against the scoreboard head
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (!PREADY) begin
                waits++;
                check("pslverr_without_pready", 8'(PSLVERR), 8'h00);
            end else if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pready: got completion, expected none at %0t", $time);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("wait_cycles", 8'(waits), 8'(EXP_WAITS));
                check("pslverr", 8'(PSLVERR), 8'(e.err));
                if (e.is_read) check("prdata", PRDATA, e.rdata);
                waits = 0;
            end
        end else begin
            waits = 0;
            check("pready_outside_access", 8'(PREADY), 8'h00);
        end
    end

    // One APB transfer starting at #1 after a rising edge; bus fields are
    // scrambled during the access phase, which the completer must ignore
    task automatic xfer(input bit wr, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input bit exp_err);
        sb_t e;
        bit  done;
        e.is_read = !wr;
        e.rdata   = exp_rd;
        e.err     = exp_err;
        sb_q.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PADDR = a ^ 16'h00F0; PWDATA = ~d; PWRITE = !wr;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge PCLK);
            if (PREADY) done = 1'b1;
            else begin @(posedge PCLK); #1; end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL pready_timeout: got no PREADY, expected one for addr 0x%04h", a);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;

        // Reset
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_prdata", PRDATA, 8'h00);
        check("reset_pready", 8'(PREADY), 8'h00);
        check("reset_pslverr", 8'(PSLVERR), 8'h00);
        PRESET = 1'b1;
        xfer(0, 16'h0042, 8'h00, 8'h00, 0);

        // Write then read
        xfer(1, 16'h0010, 8'hA5, 8'h00, 0);
        xfer(0, 16'h0010, 8'h00, 8'hA5, 0);

        // Out of range, no aliasing into the window
        xfer(1, 16'h0100, 8'h55, 8'h00, 1);
        xfer(0, 16'h0100, 8'h00, 8'h00, 1);
        xfer(0, 16'h00FF, 8'h00, 8'h00, 0);
        xfer(0, 16'h0000, 8'h00, 8'h00, 0);
        xfer(0, 16'hFFFF, 8'h00, 8'h00, 1);

        // Abort in access cycle 1 leaves the old value
        xfer(1, 16'h0020, 8'h99, 8'h00, 0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0020; PWDATA = 8'h3C;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("abort_pready", 8'(PREADY), 8'h00);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;
        xfer(0, 16'h0020, 8'h00, 8'h99, 0);

        // Back-to-back writes and reads with no idle cycles
        xfer(1, 16'h0000, 8'h11, 8'h00, 0);
        xfer(1, 16'h0001, 8'h22, 8'h00, 0);
        xfer(1, 16'h0002, 8'h33, 8'h00, 0);
        xfer(1, 16'h0003, 8'h44, 8'h00, 0);
        xfer(0, 16'h0000, 8'h00, 8'h11, 0);
        xfer(0, 16'h0001, 8'h00, 8'h22, 0);
        xfer(0, 16'h0002, 8'h00, 8'h33, 0);
        xfer(0, 16'h0003, 8'h00, 8'h44, 0);
        xfer(0, 16'h00F0, 8'h00, 8'h00, 0);

        // Asynchronous reset during a wait cycle of a write
        xfer(1, 16'h0005, 8'h5A, 8'h00, 0);
        xfer(0, 16'h0005, 8'h00, 8'h5A, 0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0005; PWDATA = 8'h77;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        #2;
        check("pre_reset_prdata", PRDATA, 8'h5A);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        check("async_reset_prdata", PRDATA, 8'h00);
        check("async_reset_pready", 8'(PREADY), 8'h00);
        check("async_reset_pslverr", 8'(PSLVERR), 8'h00);
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        xfer(0, 16'h0005, 8'h00, 8'h00, 0);
        xfer(0, 16'h0010, 8'h00, 8'h00, 0);

        // Drain the scoreboard
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge PCLK);
        check("scoreboard_drained", 8'(sb_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
